ps2_key_ctrl: RTL and testbench

Sequencer for the PS/2 keyboard path. It consumes raw scancode bytes from the PS/2 receiver and tracks the make/break/extended prefix state machine. It applies shift and caps-lock, and drives the combinational scancode-to-ASCII lookup through a registered key port. Resolved characters are queued in a small FIFO for the display/text consumer, together with a keystroke counter and a held-key indicator for the seven-segment front panel.

---
 rtl/ps2_key_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard sequencer: tracks E0/F0 prefix state, applies shift and
// caps-lock to the scancode-to-ASCII lookup result, and queues resolved
// characters in a small FIFO. Also keeps a keystroke counter and a held-key
// indicator for the front panel.
module ps2_key_ctrl #(
  parameter int DEPTH     = 4,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] lut_key,
  input  logic [7:0] lut_asc,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] key_cnt,
  output logic       held,
  output logic [7:0] held_code,
  output logic       caps,
  output logic       overflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, LOOK} state_t;

  state_t            state_q, state_d;
  logic [7:0]        lut_key_q, lut_key_d;
  logic              shift_q, shift_d;
  logic              caps_q, caps_d;
  logic              held_q, held_d;
  logic [7:0]        held_code_q, held_code_d;
  logic [7:0]        key_cnt_q, key_cnt_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;

  logic              accept, push_req, push_ok, pop, full, is_new;
  logic [7:0]        push_data;

  assign full = (cnt_q == (AW+1)'(DEPTH));

  // Prefix/make/break sequencing, LOOK resolution and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    lut_key_d   = lut_key_q;
    shift_d     = shift_q;
    caps_d      = caps_q;
    held_d      = held_q;
    held_code_d = held_code_q;
    key_cnt_d   = key_cnt_q;
    overflow_d  = overflow_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    push_req    = 1'b0;
    is_new      = 1'b0;
    accept      = in_valid && (state_q != LOOK);

    // Letters flip case when exactly one of shift/caps is active
    if ((lut_asc >= 8'd97) && (lut_asc <= 8'd122) && (shift_q ^ caps_q))
      push_data = lut_asc - 8'd32;
    else
      push_data = lut_asc;

    unique case (state_q)
      IDLE: if (accept) begin
        if (in_data == 8'hE0)      state_d = EXT;
        else if (in_data == 8'hF0) state_d = BRK;
        else if ((in_data == 8'h12) || (in_data == 8'h59)) shift_d = 1'b1;
        else if (in_data == 8'h58) begin
          // Typematic repeats of a held caps key must not re-toggle
          if (held_code_q != 8'h58) caps_d = ~caps_q;
          held_code_d = 8'h58;
        end else begin
          lut_key_d = in_data;
          state_d   = LOOK;
        end
      end
      EXT: if (accept) state_d = (in_data == 8'hF0) ? EXT_BRK : IDLE;
      EXT_BRK: if (accept) state_d = IDLE;
      BRK: if (accept) begin
        if ((in_data == 8'h12) || (in_data == 8'h59)) shift_d = 1'b0;
        if (in_data == held_code_q) begin
          held_d      = 1'b0;
          held_code_d = 8'h00;
        end
        state_d = IDLE;
      end
      LOOK: begin
        state_d = IDLE;
        if (lut_asc != 8'h00) begin
          is_new = !held_q || (lut_key_q != held_code_q);
          if (is_new) begin
            push_req    = 1'b1;
            key_cnt_d   = key_cnt_q + 8'd1;
            held_d      = 1'b1;
            held_code_d = lut_key_q;
          end else begin
            push_req = REPEAT_EN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    pop     = (cnt_q != '0) && out_ready;
    push_ok = push_req && (!full || pop);
    if (push_req && full && !pop) overflow_d = 1'b1;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      lut_key_q   <= 8'h00;
      shift_q     <= 1'b0;
      caps_q      <= 1'b0;
      held_q      <= 1'b0;
      held_code_q <= 8'h00;
      key_cnt_q   <= 8'h00;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      lut_key_q   <= lut_key_d;
      shift_q     <= shift_d;
      caps_q      <= caps_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      key_cnt_q   <= key_cnt_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign in_ready  = (state_q != LOOK);
  assign lut_key   = lut_key_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign key_cnt   = key_cnt_q;
  assign held      = held_q;
  assign held_code = held_code_q;
  assign caps      = caps_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: one instance with typematic repeat
// enabled, one with it disabled, sharing the input stream.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready, out_valid, held, caps, overflow;
  logic [7:0] lut_key, lut_asc, out_data, key_cnt, held_code;
  logic       in_ready_n, out_valid_n, held_n, caps_n, overflow_n;
  logic [7:0] lut_key_n, lut_asc_n, out_data_n, key_cnt_n, held_code_n;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Small scancode-to-lowercase-ASCII table
  function automatic logic [7:0] lut(input logic [7:0] k);
    case (k)
      8'h1C: lut = 8'h61;  // a
      8'h32: lut = 8'h62;  // b
      8'h21: lut = 8'h63;  // c
      8'h23: lut = 8'h64;  // d
      8'h24: lut = 8'h65;  // e
      8'h2B: lut = 8'h66;  // f
      8'h16: lut = 8'h31;  // 1
      8'h75: lut = 8'h38;  // keypad 8
      default: lut = 8'h00;
    endcase
  endfunction

  assign lut_asc   = lut(lut_key);
  assign lut_asc_n = lut(lut_key_n);

  ps2_key_ctrl #(.DEPTH(4), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .clrn(clrn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .lut_key(lut_key), .lut_asc(lut_asc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .key_cnt(key_cnt), .held(held), .held_code(held_code), .caps(caps),
    .overflow(overflow));

  ps2_key_ctrl #(.DEPTH(4), .REPEAT_EN(1'b0)) dut_n (
    .clk(clk), .clrn(clrn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_n), .lut_key(lut_key_n), .lut_asc(lut_asc_n),
    .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .key_cnt(key_cnt_n), .held(held_n), .held_code(held_code_n), .caps(caps_n),
    .overflow(overflow_n));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte, waiting out LOOK; returns 1ns after the accepting edge
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_wait", {7'd0, in_ready}, 8'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_data",  out_data, 8'h00);
    chk("rst_in_ready",  {7'd0, in_ready}, 8'd1);
    chk("rst_lut_key",   lut_key, 8'h00);
    chk("rst_key_cnt",   key_cnt, 8'h00);
    chk("rst_held",      {7'd0, held}, 8'd0);
    chk("rst_held_code", held_code, 8'h00);
    chk("rst_caps",      {7'd0, caps}, 8'd0);
    chk("rst_overflow",  {7'd0, overflow}, 8'd0);
    clrn = 1'b1;

    // Single make with latency check, then its break
    send(8'h1C);
    chk("t1_lut_key",   lut_key, 8'h1C);
    chk("t1_in_ready",  {7'd0, in_ready}, 8'd0);
    chk("t1_early_vld", {7'd0, out_valid}, 8'd0);
    @(posedge clk); #1;
    chk("t1_out_valid", {7'd0, out_valid}, 8'd1);
    chk("t1_out_data",  out_data, 8'h61);
    chk("t1_key_cnt",   key_cnt, 8'd1);
    chk("t1_held",      {7'd0, held}, 8'd1);
    chk("t1_held_code", held_code, 8'h1C);
    chk("t1_in_ready2", {7'd0, in_ready}, 8'd1);
    send(8'hF0); send(8'h1C); settle();
    chk("t1_held_brk",  {7'd0, held}, 8'd0);
    chk("t1_code_brk",  held_code, 8'h00);
    pop_chk("t1_pop", 8'h61);
    @(negedge clk);
    chk("t1_empty", {7'd0, out_valid}, 8'd0);

    // Shift applies to letters and clears on its break
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C); settle();
    pop_chk("t2_upper", 8'h41);
    pop_chk("t2_lower", 8'h61);
    chk("t2_key_cnt", key_cnt, 8'd3);
    send(8'hF0); send(8'h1C);

    // Caps-lock, and caps xor shift; non-letters pass unchanged
    send(8'h58); send(8'hF0); send(8'h58); settle();
    chk("t3_caps", {7'd0, caps}, 8'd1);
    chk("t3_code_after_caps_brk", held_code, 8'h00);
    send(8'h32); send(8'hF0); send(8'h32);
    send(8'h12); send(8'h32); send(8'h16); settle();
    pop_chk("t3_caps_b", 8'h42);
    pop_chk("t3_xor_b",  8'h62);
    pop_chk("t3_digit",  8'h31);
    chk("t3_key_cnt", key_cnt, 8'd6);
    send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
    // Held caps key toggles only once
    send(8'h58); send(8'h58); settle();
    chk("t3_caps_held", {7'd0, caps}, 8'd0);
    chk("t3_caps_code", held_code, 8'h58);
    chk("t3_caps_noheld", {7'd0, held}, 8'd0);
    send(8'hF0); send(8'h58);

    // Typematic repeat: three pushes vs. one
    send(8'h1C); send(8'h1C); send(8'h1C); settle();
    chk("t4_cnt_rep",   key_cnt, 8'd7);
    chk("t4_cnt_norep", key_cnt_n, 8'd7);
    pop_chk("t4_rep0", 8'h61);
    @(negedge clk);
    chk("t4_norep_empty", {7'd0, out_valid_n}, 8'd0);
    pop_chk("t4_rep1", 8'h61);
    pop_chk("t4_rep2", 8'h61);
    @(negedge clk);
    chk("t4_rep_empty", {7'd0, out_valid}, 8'd0);
    send(8'hF0); send(8'h1C);

    // Extended make/break discarded; unmapped key ignored
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h07); settle();
    chk("t5_out_valid", {7'd0, out_valid}, 8'd0);
    chk("t5_key_cnt",   key_cnt, 8'd7);
    chk("t5_held",      {7'd0, held}, 8'd0);
    chk("t5_held_code", held_code, 8'h00);
    chk("t5_in_ready",  {7'd0, in_ready}, 8'd1);

    // Overflow: five makes into four entries
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24); settle();
    chk("t6_overflow", {7'd0, overflow}, 8'd1);
    chk("t6_key_cnt",  key_cnt, 8'd12);
    chk("t6_head",     out_data, 8'h61);
    // Pop in the same cycle as the sixth push
    send(8'h2B);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    pop_chk("t6_q0", 8'h62);
    pop_chk("t6_q1", 8'h63);
    pop_chk("t6_q2", 8'h64);
    pop_chk("t6_q3", 8'h66);
    @(negedge clk);
    chk("t6_empty", {7'd0, out_valid}, 8'd0);
    chk("t6_key_cnt2", key_cnt, 8'd13);

    // Asynchronous reset mid E0 F0
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'h1C); settle();
    send(8'hE0); send(8'hF0);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("t7_out_valid", {7'd0, out_valid}, 8'd0);
    chk("t7_out_data",  out_data, 8'h00);
    chk("t7_lut_key",   lut_key, 8'h00);
    chk("t7_key_cnt",   key_cnt, 8'h00);
    chk("t7_held",      {7'd0, held}, 8'd0);
    chk("t7_held_code", held_code, 8'h00);
    chk("t7_caps",      {7'd0, caps}, 8'd0);
    chk("t7_overflow",  {7'd0, overflow}, 8'd0);
    chk("t7_in_ready",  {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    clrn = 1'b1;
    // Sequencer restarts in IDLE: the next make is resolved
    send(8'h1C); settle();
    chk("t7_cnt_after", key_cnt, 8'd1);
    pop_chk("t7_pop", 8'h61);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
